// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// State encoding keeps bit 1 equal to the accepted level.
package debounce_pkg;

    localparam logic [1:0] ENC_STABLE_LOW  = 2'b00;
    localparam logic [1:0] ENC_WAIT_HIGH   = 2'b01;
    localparam logic [1:0] ENC_STABLE_HIGH = 2'b11;
    localparam logic [1:0] ENC_WAIT_LOW    = 2'b10;

    typedef enum logic [1:0] {
        STABLE_LOW  = ENC_STABLE_LOW,
        WAIT_HIGH   = ENC_WAIT_HIGH,
        STABLE_HIGH = ENC_STABLE_HIGH,
        WAIT_LOW    = ENC_WAIT_LOW
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES = 50000;
    localparam int DEFAULT_CNT_WIDTH     = 16;

    function automatic logic level_of(input state_t st);
        return st[1];
    endfunction

    function automatic logic is_waiting(input state_t st);
        return st[1] ^ st[0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
// Brings an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= i_d;
            r_s1 <= r_s0;
        end
    end

    assign o_q = r_s1;

endmodule

// File: rtl/debounce_fsm.sv
// Debouncer: 2-flop sync followed by a stable-count FSM that emits
// a registered clean level plus one-cycle rise/fall strobes.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic sig_clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    if (STABLE_CYCLES < 2 ||
        longint'(STABLE_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1))
    begin : g_bad_params
        $error("debounce_fsm: STABLE_CYCLES out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 w_s;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;
    logic                 r_sig;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_busy;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (raw_in),
        .o_q (w_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter clears on any state change or return to the old level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            STABLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HIGH;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_LOW;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
            end
        endcase
    end

    // Outputs decode the next state so they line up with the state flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_sig  <= level_of(w_state_nxt);
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_busy <= is_waiting(w_state_nxt);
        end
    end

    assign sig_clean  = r_sig;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule
